interval_timer: RTL and testbench

Measures the number of clock cycles between a start event and a stop event and reports the result as a binary count. Whereas the load-and-count-down timer turns a programmed count into a done pulse, this block turns an observed interval into a count. Counting uses a carry-save accumulator, so the per-cycle logic depth is constant and independent of width. After stop, the accumulator is resolved to binary by a bit-serial adder. It sits beside the existing counter blocks, for latency measurement and self-calibration of delays.

---
 rtl/interval_timer_pkg.sv | 11 +
 rtl/compressor2.sv | 15 +
 rtl/interval_timer_serial_adder.sv | 51 +++++
 rtl/interval_timer.sv | 119 +++++++++++
 tb/tb_interval_timer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: FSM state encoding.
package interval_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/compressor2.sv
// Two-input bitwise compressor: produces the sum (xor) and generate (and)
// terms used by the carry-save increment.
module compressor2 #(
  parameter int width = 0
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] x,
  output logic [width-1:0] g
);

  assign x = a ^ b;
  assign g = a & b;

endmodule

// File: rtl/interval_timer_serial_adder.sv
// Bit-serial adder that resolves the carry-save pair into a binary value,
// LSB first, one bit per shift cycle. The final carry-out is dropped.
module serial_adder #(
  parameter int width = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             done,
  output logic [width-1:0] sum
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  logic [width-1:0] ra;
  logic [width-1:0] rb;
  logic             carry;
  logic [CW-1:0]    bitcnt;
  logic             sbit;

  assign sbit = ra[0] ^ rb[0] ^ carry;
  // done flags the shift that produces the MSB, so the sum is complete after it
  assign done = shift && (bitcnt == LAST);

  // Capture operands on load, then shift one resolved bit into sum per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      carry  <= 1'b0;
      bitcnt <= '0;
      sum    <= '0;
    end else if (load) begin
      ra     <= a;
      rb     <= b;
      carry  <= 1'b0;
      bitcnt <= '0;
    end else if (shift) begin
      ra     <= ra >> 1;
      rb     <= rb >> 1;
      carry  <= (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
      sum    <= {sbit, sum[width-1:1]};
      bitcnt <= bitcnt + CW'(1);
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Interval timer: counts cycles from start to stop in carry-save form so the
// per-cycle logic depth is width-independent, then resolves the count to
// binary with a bit-serial adder and reports it with a one-cycle vld.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int width = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             vld,
  output logic [width-1:0] cnt,
  output logic             ovf
);

  state_t           state;
  logic [width-1:0] s;
  logic [width-1:0] c;
  logic [width-1:0] x;
  logic [width-1:0] g;
  logic [width-1:0] s_nxt;
  logic [width-1:0] c_nxt;
  logic             ovf_bit;
  logic [width-1:0] cnt_q;
  logic             ovf_q;
  logic             load;
  logic             shift;
  logic             add_done;
  logic [width-1:0] sum;

  compressor2 #(.width(width)) u_cmp (
    .a(s),
    .b(c),
    .x(x),
    .g(g)
  );

  // Carry-save increment: V' = (s ^ c) + ((s & c) << 1) + 1; the +1 fills the
  // LSB that the shifted generate term leaves empty.
  assign s_nxt = x;
  assign c_nxt = {g[width-2:0], 1'b1};

  // The adder loads the post-increment pair on the stop edge
  assign load  = (state == COUNT) && !start && stop;
  assign shift = (state == RESOLVE);

  serial_adder #(.width(width)) u_add (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .a    (s_nxt),
    .b    (c_nxt),
    .done (add_done),
    .sum  (sum)
  );

  // Measurement sequencing: clear/count in carry-save, resolve, then report
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      c       <= '0;
      ovf_bit <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s       <= '0;
            c       <= '0;
            ovf_bit <= 1'b0;
            state   <= COUNT;
          end
        end
        COUNT: begin
          if (start) begin
            s       <= '0;
            c       <= '0;
            ovf_bit <= 1'b0;
          end else begin
            s <= s_nxt;
            c <= c_nxt;
            if (g[width-1]) ovf_bit <= 1'b1;
            if (stop) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          if (add_done) state <= DONE;
        end
        DONE: begin
          cnt_q <= sum;
          ovf_q <= ovf_bit;
          if (start) begin
            s       <= '0;
            c       <= '0;
            ovf_bit <= 1'b0;
            state   <= COUNT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and registers only; during DONE the
  // freshly resolved result is presented before it is latched into cnt_q.
  assign busy = (state == COUNT) || (state == RESOLVE);
  assign vld  = (state == DONE);
  assign cnt  = vld ? sum : cnt_q;
  assign ovf  = vld ? ovf_bit : ovf_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer (width = 5): table-driven intervals
// plus hand-written corner sequences, with results checked via a scoreboard.
module tb_interval_timer;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         busy;
  logic         vld;
  logic [W-1:0] cnt;
  logic         ovf;

  interval_timer #(.width(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .busy (busy),
    .vld  (vld),
    .cnt  (cnt),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  typedef struct {
    int cnt;
    int ovf;
    int at;
  } exp_t;

  typedef struct {
    int n;
    int cnt;
    int ovf;
  } vec_t;

  exp_t q[$];
  vec_t vecs[6];
  logic prev_vld = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every vld must match the oldest outstanding result
  always @(negedge clk) begin
    if (vld) begin
      exp_t e;
      check("vld_width", int'(prev_vld), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vld: got vld=1 cnt=%0d expected no result (edge %0d)", cnt, edge_n);
      end else begin
        e = q.pop_front();
        check("cnt", int'(cnt), e.cnt);
        check("ovf", int'(ovf), e.ovf);
        check("vld_latency", edge_n, e.at);
        check("busy_in_done", int'(busy), 0);
      end
    end
    prev_vld = vld;
  end

  task automatic push_exp(input int cnt_e, input int ovf_e);
    exp_t e;
    e.cnt = cnt_e;
    e.ovf = ovf_e;
    e.at  = edge_n + W;
    q.push_back(e);
  endtask

  // Start at the next edge, stop n edges later, queue the expected result
  task automatic measure(input int n, input int cnt_e, input int ovf_e);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    repeat (n - 1) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push_exp(cnt_e, ovf_e);
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (q.size() > 0 && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    tick();
  endtask

  initial begin
    vecs[0] = '{n: 7,  cnt: 7,  ovf: 0};
    vecs[1] = '{n: 40, cnt: 8,  ovf: 1};
    vecs[2] = '{n: 3,  cnt: 3,  ovf: 0};
    vecs[3] = '{n: 31, cnt: 31, ovf: 0};
    vecs[4] = '{n: 2,  cnt: 2,  ovf: 0};
    vecs[5] = '{n: 12, cnt: 12, ovf: 0};

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_vld", int'(vld), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      measure(vecs[i].n, vecs[i].cnt, vecs[i].ovf);
      drain();
      check("cnt_hold", int'(cnt), vecs[i].cnt);
    end

    // start and stop together: the same-cycle stop is ignored
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b0;
    push_exp(1, 0);
    drain();

    // restart mid-count: only the second interval is reported
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    measure(4, 4, 0);
    drain();

    // reset during RESOLVE aborts the measurement
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_vld", int'(vld), 0);
    check("abort_cnt", int'(cnt), 0);
    check("abort_ovf", int'(ovf), 0);
    repeat (10) tick();
    measure(6, 6, 0);
    drain();

    // stop in IDLE is ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop_busy", int'(busy), 0);
    repeat (3) tick();
    check("idle_stop_busy2", int'(busy), 0);

    // start during RESOLVE is ignored
    measure(9, 9, 0);
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resolve_busy", int'(busy), 1);
    drain();
    repeat (10) tick();
    check("no_extra_busy", int'(busy), 0);

    // back-to-back: start sampled in the DONE cycle
    measure(3, 3, 0);
    repeat (W) tick();
    check("done_vld", int'(vld), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", int'(busy), 1);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push_exp(2, 0);
    drain();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
